// File: rtl/des_pkg.sv
// des_pkg -- shared constants and helpers for the DES core.
//   Holds the FIPS 46-3 permutation tables (IP, FP, E, P, PC1, PC2), the
//   S-box contents, the key-schedule shift constant and the FSM state type.
//   Every vector uses FIPS numbering: bit 1 is the MSB.
package des_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   localparam int IP_T [1:64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [1:64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [1:48] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int P_T [1:32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [1:56] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [1:48] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   // Encryption left-shift per round 1..16 (index 0..15).
   localparam int KS_SHIFT [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Index is {b1, b6, b2..b5}: row in the upper two bits, column below.
   localparam int SBOX [0:7][0:63] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic logic [1:64] perm_ip(input logic [1:64] x);
      logic [1:64] y;
      for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i]];
      return y;
   endfunction

   function automatic logic [1:64] perm_fp(input logic [1:64] x);
      logic [1:64] y;
      for (int i = 1; i <= 64; i++) y[i] = x[FP_T[i]];
      return y;
   endfunction

   function automatic logic [1:48] perm_e(input logic [1:32] x);
      logic [1:48] y;
      for (int i = 1; i <= 48; i++) y[i] = x[E_T[i]];
      return y;
   endfunction

   function automatic logic [1:32] perm_p(input logic [1:32] x);
      logic [1:32] y;
      for (int i = 1; i <= 32; i++) y[i] = x[P_T[i]];
      return y;
   endfunction

   // Parity bits 8, 16, ..., 64 never appear in PC1, so they drop out here.
   function automatic logic [1:56] perm_pc1(input logic [1:64] x);
      logic [1:56] y;
      for (int i = 1; i <= 56; i++) y[i] = x[PC1_T[i]];
      return y;
   endfunction

   function automatic logic [1:48] perm_pc2(input logic [1:56] x);
      logic [1:48] y;
      for (int i = 1; i <= 48; i++) y[i] = x[PC2_T[i]];
      return y;
   endfunction

   // Rotation amount for 0-based round idx. Decryption walks the encryption
   // schedule backwards: round 1 uses C0D0 as-is (C16 == C0), round n then
   // undoes encryption round 18-n.
   function automatic logic [1:0] ks_shift(input logic enc, input logic [3:0] idx);
      logic [3:0] back;
      back = 4'd0 - idx;
      if (enc)              return 2'(KS_SHIFT[idx]);
      else if (idx == 4'd0) return 2'd0;
      else                  return 2'(KS_SHIFT[back]);
   endfunction

   function automatic logic [1:28] rot28(input logic [1:28] x, input logic left,
                                         input logic [1:0] amt);
      case ({left, amt})
         3'b101:  return {x[2:28], x[1]};
         3'b110:  return {x[3:28], x[1:2]};
         3'b001:  return {x[28], x[1:27]};
         3'b010:  return {x[27:28], x[1:26]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/S_block1.sv
// S_block1 -- DES S-box 1. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block1 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[0][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/S_block2.sv
// S_block2 -- DES S-box 2. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block2 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[1][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/S_block3.sv
// S_block3 -- DES S-box 3. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block3 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[2][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/S_block4.sv
// S_block4 -- DES S-box 4. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block4 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[3][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/S_block5.sv
// S_block5 -- DES S-box 5. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block5 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[4][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/S_block6.sv
// S_block6 -- DES S-box 6. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block6 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[5][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/S_block7.sv
// S_block7 -- DES S-box 7. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block7 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[6][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/S_block8.sv
// S_block8 -- DES S-box 8. b_i: 6-bit input [1:6]; s_o: 4-bit output [1:4].
module S_block8 import des_pkg::*; (
   input  logic [1:6] b_i,
   output logic [1:4] s_o
);
   assign s_o = 4'(SBOX[7][{b_i[1], b_i[6], b_i[2:5]}]);
endmodule

// File: rtl/des_round.sv
// des_round -- one combinational DES Feistel round.
//   l_i, r_i : input halves [1:32]
//   k_i      : round key [1:48]
//   l_o, r_o : output halves; l_o = r_i, r_o = l_i ^ P(S(E(r_i) ^ k_i))
module des_round import des_pkg::*; (
   input  logic [1:32] l_i,
   input  logic [1:32] r_i,
   input  logic [1:48] k_i,
   output logic [1:32] l_o,
   output logic [1:32] r_o
);

   logic [1:48] x;
   logic [1:32] s;

   assign x = perm_e(r_i) ^ k_i;

   S_block1 u_s1 (.b_i(x[1:6]),   .s_o(s[1:4]));
   S_block2 u_s2 (.b_i(x[7:12]),  .s_o(s[5:8]));
   S_block3 u_s3 (.b_i(x[13:18]), .s_o(s[9:12]));
   S_block4 u_s4 (.b_i(x[19:24]), .s_o(s[13:16]));
   S_block5 u_s5 (.b_i(x[25:30]), .s_o(s[17:20]));
   S_block6 u_s6 (.b_i(x[31:36]), .s_o(s[21:24]));
   S_block7 u_s7 (.b_i(x[37:42]), .s_o(s[25:28]));
   S_block8 u_s8 (.b_i(x[43:48]), .s_o(s[29:32]));

   assign l_o = r_i;
   assign r_o = l_i ^ perm_p(s);

endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core -- iterative DES block decryptor, ROUNDS_PER_CYCLE rounds
// per clock (1, 2, 4, 8 or 16), latency 16/ROUNDS_PER_CYCLE after accept.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : input handshake for ciphertext and key (bit 1 = MSB)
//   out_valid / out_ready: output handshake for plaintext (zero when not valid)
//   busy                 : high while a block is in flight or waiting (RUN/DONE)
// Optional macro DES_DECRYPT_CORE_ENCRYPT_EN adds input 'encrypt', sampled at
// accept; 1 selects encryption (K1..K16, left-rotating key schedule).
module des_decrypt_core import des_pkg::*; #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:64] ciphertext,
   input  logic [1:64] key,
`ifdef DES_DECRYPT_CORE_ENCRYPT_EN
   input  logic        encrypt,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:64] plaintext,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [4:0]  rnd_q, rnd_d;          // rounds completed so far
   logic [1:32] l_q, l_d, r_q, r_d;
   logic [1:28] c_q, c_d, d_q, d_d;
   logic [1:64] pt_q, pt_d;
   logic        ov_q, ov_d;
   logic        enc_q;

`ifdef DES_DECRYPT_CORE_ENCRYPT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            enc_q <= 1'b0;
      else if (state_q == S_IDLE && in_valid) enc_q <= encrypt;
   end
`else
   assign enc_q = 1'b0;
`endif

   // Round cascade: each stage rotates C/D for its own round number, then runs
   // the Feistel round with PC2 of the rotated key halves.
   logic [1:32] l_c [0:ROUNDS_PER_CYCLE];
   logic [1:32] r_c [0:ROUNDS_PER_CYCLE];
   logic [1:28] c_c [0:ROUNDS_PER_CYCLE];
   logic [1:28] d_c [0:ROUNDS_PER_CYCLE];

   assign l_c[0] = l_q;
   assign r_c[0] = r_q;
   assign c_c[0] = c_q;
   assign d_c[0] = d_q;

   for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rnd
      logic [1:0]  sh;
      logic [1:48] kn;
      assign sh         = ks_shift(enc_q, rnd_q[3:0] + 4'(j));
      assign c_c[j + 1] = rot28(c_c[j], enc_q, sh);
      assign d_c[j + 1] = rot28(d_c[j], enc_q, sh);
      assign kn         = perm_pc2({c_c[j + 1], d_c[j + 1]});
      des_round u_round (
         .l_i (l_c[j]),
         .r_i (r_c[j]),
         .k_i (kn),
         .l_o (l_c[j + 1]),
         .r_o (r_c[j + 1])
      );
   end

   always_comb begin
      state_d  = state_q;
      rnd_d    = rnd_q;
      l_d      = l_q;
      r_d      = r_q;
      c_d      = c_q;
      d_d      = d_q;
      pt_d     = pt_q;
      ov_d     = ov_q;
      in_ready = 1'b0;
      busy     = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               {l_d, r_d} = perm_ip(ciphertext);
               {c_d, d_d} = perm_pc1(key);
               rnd_d      = '0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            l_d   = l_c[ROUNDS_PER_CYCLE];
            r_d   = r_c[ROUNDS_PER_CYCLE];
            c_d   = c_c[ROUNDS_PER_CYCLE];
            d_d   = d_c[ROUNDS_PER_CYCLE];
            rnd_d = rnd_q + 5'(ROUNDS_PER_CYCLE);
            if (rnd_q + 5'(ROUNDS_PER_CYCLE) == 5'd16) begin
               // Final swap: output is FP(R16 || L16).
               pt_d    = perm_fp({r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]});
               ov_d    = 1'b1;
               rnd_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               pt_d    = '0;
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rnd_q   <= '0;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         pt_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         pt_q    <= pt_d;
         ov_q    <= ov_d;
      end
   end

   assign out_valid = ov_q;
   assign plaintext = pt_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core -- directed known-answer bench for des_decrypt_core.
// Two instances (1 and 4 rounds per cycle) share the input side and have
// independent output handshakes.
module tb_des_decrypt_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic [1:64] ciphertext, key;
   logic        in_ready1, out_valid1, out_ready1, busy1;
   logic        in_ready4, out_valid4, out_ready4, busy4;
   logic [1:64] pt1, pt4;
`ifdef DES_DECRYPT_CORE_ENCRYPT_EN
   logic        encrypt;
`endif

   des_decrypt_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .ciphertext(ciphertext), .key(key),
`ifdef DES_DECRYPT_CORE_ENCRYPT_EN
      .encrypt(encrypt),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1), .plaintext(pt1), .busy(busy1));

   des_decrypt_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .ciphertext(ciphertext), .key(key),
`ifdef DES_DECRYPT_CORE_ENCRYPT_EN
      .encrypt(encrypt),
`endif
      .out_valid(out_valid4), .out_ready(out_ready4), .plaintext(pt4), .busy(busy4));

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [63:0] key;
      logic [63:0] ct;
      logic [63:0] pt;
   } vec_t;
   vec_t tv [0:6];

   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
   localparam logic [63:0] P2 = 64'h8787878787878787;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Accept one block on both cores, check latency and result, then drain.
   task automatic run_vec(input string name, input logic [63:0] k,
                          input logic [63:0] ct, input logic [63:0] exp);
      int lat1, lat4;
      lat1 = 0;
      lat4 = 0;
      key        = k;
      ciphertext = ct;
      in_valid   = 1'b1;
      out_ready1 = 1'b1;
      out_ready4 = 1'b1;
      step();
      in_valid   = 1'b0;
      ciphertext = '1;
      key        = '0;
      for (int cyc = 1; cyc <= 40 && (lat1 == 0 || lat4 == 0); cyc++) begin
         out_ready1 = (cyc < 3);
         out_ready4 = (cyc < 3);
         step();
         if (lat1 == 0 && out_valid1) lat1 = cyc;
         if (lat4 == 0 && out_valid4) lat4 = cyc;
      end
      chk({name, " lat1"}, 64'(lat1), 64'd16);
      chk({name, " lat4"}, 64'(lat4), 64'd4);
      chk({name, " pt1"}, pt1, exp);
      chk({name, " pt4"}, pt4, exp);
      out_ready1 = 1'b1;
      out_ready4 = 1'b1;
      step();
      out_ready1 = 1'b0;
      out_ready4 = 1'b0;
      chk({name, " idle"}, 64'({out_valid1, out_valid4, in_ready1, in_ready4, busy1, busy4}),
          64'b001100);
      chk({name, " ptclr"}, pt1 | pt4, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      n_cmp      = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready1 = 1'b0;
      out_ready4 = 1'b0;
      key        = '0;
      ciphertext = '0;
`ifdef DES_DECRYPT_CORE_ENCRYPT_EN
      encrypt    = 1'b0;
`endif
      tv[0] = '{K1, C1, P1};
      tv[1] = '{K2, 64'h0, P2};
      tv[2] = '{64'h123556789ABDDEF0, C1, P1};        // K1 with every parity bit flipped
      tv[3] = '{64'h0F339333EB6C0C72, 64'h0, P2};     // K2 with every parity bit flipped
      tv[4] = '{64'h0, 64'h8CA64DE9C1B123A7, 64'h0};
      tv[5] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};
      tv[6] = '{64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074};

      #12;
      chk("rst flags", 64'({out_valid1, out_valid4, busy1, busy4}), 64'd0);
      chk("rst pt", pt1 | pt4, 64'd0);
      rst_n = 1'b1;
      step();
      chk("rst ready", 64'({in_ready1, in_ready4}), 64'b11);

      for (int i = 0; i < 7; i++)
         run_vec($sformatf("tv%0d", i), tv[i].key, tv[i].ct, tv[i].pt);

      // Backpressure: both cores sit in DONE for 10 cycles, a second
      // in_valid pulse arrives and must be ignored.
      key        = K1;
      ciphertext = C1;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !out_valid1; i++) step();
      for (int i = 0; i < 10; i++) begin
         in_valid   = (i == 3);
         key        = K2;
         ciphertext = 64'h0;
         step();
         chk("bp flags", 64'({out_valid1, in_ready1, busy1, out_valid4, in_ready4, busy4}),
             64'b101101);
         chk("bp pt", pt1 ^ pt4 ^ P1, P1);
      end
      in_valid   = 1'b0;
      out_ready1 = 1'b1;
      out_ready4 = 1'b1;
      step();
      out_ready1 = 1'b0;
      out_ready4 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         seen |= out_valid1 | out_valid4 | busy1 | busy4;
      end
      chk("bp pulse ignored", 64'(seen), 64'd0);

      // Reset after round 7 of the single-round core.
      key        = K2;
      ciphertext = 64'h0;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      rst_n = 1'b0;
      #1;
      chk("rr flags", 64'({out_valid1, busy1, out_valid4, busy4}), 64'd0);
      chk("rr pt", pt1 | pt4, 64'd0);
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         seen |= out_valid1 | out_valid4;
      end
      chk("rr no out_valid", 64'(seen), 64'd0);
      run_vec("rr next", K1, C1, P1);

`ifdef DES_DECRYPT_CORE_ENCRYPT_EN
      encrypt = 1'b1;
      run_vec("enc", K1, P1, C1);
      encrypt = 1'b0;
      run_vec("enc back", K1, C1, P1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/des_decrypt_core.md
DES_DECRYPT_CORE -- requirements
Module: des_decrypt_core

Interface
REQ-001 Parameter ROUNDS_PER_CYCLE, default 1, number of DES rounds computed per clock; legal values 1, 2, 4, 8 and 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  ciphertext and key present.
REQ-005 in_ready  output  1  core can accept a block.
REQ-006 ciphertext  input  [1:64]  DES block; bit 1 is the MSB, per FIPS 46-3 numbering.
REQ-007 key  input  [1:64]  DES key including parity bits 8, 16, ..., 64 (ignored).
REQ-008 out_valid  output  1  plaintext valid.
REQ-009 out_ready  input  1  consumer accepts plaintext.
REQ-010 plaintext  output  [1:64]  decrypted block, bit 1 is the MSB.
REQ-011 busy  output  1  high in RUN and DONE.

Function
REQ-012 FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on in_valid && in_ready.
- RUN -> DONE after the final round.
- DONE -> IDLE on out_ready.
REQ-013 in_ready SHALL be 1 only in IDLE; input is accepted only on the edge where in_valid && in_ready.
REQ-014 Accept edge T SHALL register L0||R0 = IP(ciphertext) and C||D = PC1(key); no output changes at T.
REQ-015 Edges T+1 .. T+16/ROUNDS_PER_CYCLE SHALL each compute ROUNDS_PER_CYCLE Feistel rounds: L' = R, R' = L xor P(S(E(R) xor Kn)).
REQ-016 Round keys SHALL be applied in order K16 down to K1, using a right-rotating key schedule seeded from C0||D0:
- decryption round 1: no rotation;
- decryption rounds 2, 9 and 16: rotate right by 1;
- all other rounds: rotate right by 2;
- Kn = PC2(C||D) after that round's rotation.
REQ-017 S(.) SHALL be formed from the existing S-box blocks S_block1..S_block8, instantiated once per combinational round, each taking a 6-bit slice [1:6] and returning [1:4].
REQ-018 On edge T+16/ROUNDS_PER_CYCLE the core SHALL register plaintext = FP(R16||L16) (halves swapped) and set out_valid = 1.
REQ-019 In DONE, plaintext and out_valid SHALL hold stable until out_ready = 1; on that edge out_valid drops and the FSM returns to IDLE.
REQ-020 in_ready SHALL rise the cycle after the out_ready handshake; back-to-back throughput is one block per 16/ROUNDS_PER_CYCLE + 2 cycles.
REQ-021 in_valid SHALL be ignored while busy; ciphertext and key may change freely after acceptance.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 plaintext SHALL read all-zero whenever out_valid = 0.

Reset
REQ-024 rst_n = 0 SHALL immediately force state = IDLE, in_ready = 1 (once released), out_valid = 0, busy = 0, plaintext = 0, and clear the round counter, L/R and C/D registers.
REQ-025 A reset asserted during RUN or DONE SHALL abort the block; no out_valid pulse may follow the release of reset.

Configuration
REQ-026 Macro DES_DECRYPT_CORE_ENCRYPT_EN, when defined, SHALL add input port encrypt (1 bit), sampled at the accept edge.
- encrypt = 1: use K1..K16 with the left-rotating schedule (shift 1 at rounds 1, 2, 9, 16; otherwise 2).
- encrypt = 0: decrypt exactly as in REQ-016.
REQ-027 When DES_DECRYPT_CORE_ENCRYPT_EN is undefined, the port SHALL be absent and the core SHALL decrypt only.

Structure
REQ-028 Package des_pkg SHALL hold the following; the core SHALL contain no table literals:
- IP, FP, E, P, PC1 and PC2 permutation tables;
- the shift-schedule constant;
- the FSM state typedef.
REQ-029 One sub-module, des_round (combinational: R, L, Kn -> L', R'), SHALL instantiate S_block1..S_block8; the core SHALL instantiate ROUNDS_PER_CYCLE copies in cascade.

Verification
REQ-030 Known answer: key 133457799BBCDFF1, ciphertext 85E813540F0AB405 -> plaintext 0123456789ABCDEF, with out_valid 16 cycles after the accept edge (ROUNDS_PER_CYCLE = 1).
REQ-031 Known answer: key 0E329232EA6D0D73, ciphertext 0000000000000000 -> plaintext 8787878787878787; repeat with ROUNDS_PER_CYCLE = 4 and check latency is 4 cycles.
REQ-032 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> plaintext and out_valid stable and in_ready = 0 throughout; second in_valid pulse ignored.
REQ-033 Reset mid-RUN: assert rst_n = 0 at round 7 -> outputs zero at once, no out_valid after release; next block decrypts correctly.
REQ-034 With DES_DECRYPT_CORE_ENCRYPT_EN defined: encrypt = 1, key 133457799BBCDFF1, input 0123456789ABCDEF -> 85E813540F0AB405; then decrypting that result returns the original.
REQ-035 Parity insensitivity: flip all key bits 8, 16, ..., 64 in the REQ-030 vector -> identical plaintext.
